exec_datapath: RTL and testbench

Parametrised, self-sequencing successor to the lab datapath: register file, A/B operand registers, shifter, ALU, C result register and NVZ status register, driven by an internal state machine instead of external load strobes. A controller issues one command per `start`/`done` handshake; the block performs read, execute and writeback itself. It sits between the instruction decoder and memory interface in the next-generation CPU.

---
 rtl/exec_datapath_pkg.sv | 33 +++
 rtl/exec_datapath_dp_regfile.sv | 40 ++++
 rtl/exec_datapath.sv | 189 ++++++++++++++++++
 tb/tb_exec_datapath.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/exec_datapath_pkg.sv
// Shared command, ALU-op, shift and FSM state encodings for exec_datapath.
package exec_datapath_pkg;

  typedef enum logic [1:0] {
    CMD_ALU  = 2'd0,
    CMD_MOVI = 2'd1,
    CMD_LDM  = 2'd2,
    CMD_CMP  = 2'd3
  } cmd_e;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_AND = 2'd2,
    OP_MVN = 2'd3
  } alu_op_e;

  typedef enum logic [1:0] {
    SH_NONE = 2'd0,
    SH_LSL1 = 2'd1,
    SH_LSR1 = 2'd2,
    SH_ASR1 = 2'd3
  } shift_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RDA  = 3'd1,
    ST_RDB  = 3'd2,
    ST_EXEC = 3'd3,
    ST_WB   = 3'd4
  } state_e;

endpackage

// File: rtl/exec_datapath_dp_regfile.sv
// Register file: one synchronous write port, two async read ports, async clear.
// Optional debug read port when EXEC_DATAPATH_DBG_EN is defined.
module dp_regfile #(
  parameter int DATA_W = 16,
  parameter int NREG   = 8,
  localparam int AW    = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_a_i,
  input  logic [AW-1:0]     raddr_b_i,
  output logic [DATA_W-1:0] rdata_a_o,
  output logic [DATA_W-1:0] rdata_b_o
`ifdef EXEC_DATAPATH_DBG_EN
  ,
  input  logic [AW-1:0]     dbg_addr_i,
  output logic [DATA_W-1:0] dbg_data_o
`endif
);

  logic [DATA_W-1:0] regs_q [NREG];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= {DATA_W{1'b0}};
    end else if (we_i) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = regs_q[raddr_a_i];
  assign rdata_b_o = regs_q[raddr_b_i];
`ifdef EXEC_DATAPATH_DBG_EN
  assign dbg_data_o = regs_q[dbg_addr_i];
`endif

endmodule

// File: rtl/exec_datapath.sv
// Self-sequencing datapath: regfile, A/B/C registers, shifter, ALU and NVZ flags.
// Define EXEC_DATAPATH_DBG_EN to add the dbg_addr/dbg_data register read port.
module exec_datapath
  import exec_datapath_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int NREG    = 8,
  parameter int PC_W    = 8,
  localparam int REG_AW = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [1:0]        cmd,
  input  logic [1:0]        alu_op,
  input  logic [1:0]        shift,
  input  logic [REG_AW-1:0] rd,
  input  logic [REG_AW-1:0] rn,
  input  logic [REG_AW-1:0] rm,
  input  logic              asel,
  input  logic              bsel,
  input  logic [DATA_W-1:0] sximm5,
  input  logic [DATA_W-1:0] sximm8,
  input  logic [DATA_W-1:0] mdata,
  input  logic [PC_W-1:0]   pc,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] c_out,
  output logic              n_flag,
  output logic              v_flag,
  output logic              z_flag
`ifdef EXEC_DATAPATH_DBG_EN
  ,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
`endif
);

  state_e            state_q, state_d;
  cmd_e              cmd_q;
  alu_op_e           op_q;
  shift_e            shift_q;
  logic [REG_AW-1:0] rd_q, rn_q, rm_q;
  logic              asel_q, bsel_q;
  logic [DATA_W-1:0] sximm5_q, wbval_q;
  logic [DATA_W-1:0] a_q, b_q, c_q;
  logic              n_q, v_q, z_q, done_q, busy_q;

  logic              accept_s, done_d, we_s;
  logic [DATA_W-1:0] rdata_a_s, rdata_b_s, wdata_s;
  logic [DATA_W-1:0] b_sh_s, opa_s, opb_s, res_s;
  logic              v_s;

  assign accept_s = (state_q == ST_IDLE) && start;
  assign we_s     = (state_q == ST_WB);
  assign wdata_s  = (cmd_q == CMD_ALU) ? c_q : wbval_q;

  dp_regfile #(.DATA_W(DATA_W), .NREG(NREG)) u_regfile (
    .clk       (clk),
    .reset_n   (reset_n),
    .we_i      (we_s),
    .waddr_i   (rd_q),
    .wdata_i   (wdata_s),
    .raddr_a_i (rn_q),
    .raddr_b_i (rm_q),
    .rdata_a_o (rdata_a_s),
    .rdata_b_o (rdata_b_s)
`ifdef EXEC_DATAPATH_DBG_EN
    ,
    .dbg_addr_i(dbg_addr),
    .dbg_data_o(dbg_data)
`endif
  );

  // Sequencing: ALU/CMP read both operands first; MOVI/LDM go straight to writeback.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          case (cmd_e'(cmd))
            CMD_ALU, CMD_CMP:  state_d = ST_RDA;
            CMD_MOVI, CMD_LDM: state_d = ST_WB;
            default:           state_d = ST_IDLE;
          endcase
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RDA:  state_d = ST_RDB;
      ST_RDB:  state_d = ST_EXEC;
      ST_EXEC: state_d = (cmd_q == CMD_CMP) ? ST_IDLE : ST_WB;
      ST_WB:   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign done_d = (state_q == ST_WB) || ((state_q == ST_EXEC) && (cmd_q == CMD_CMP));

  always_comb begin
    case (shift_q)
      SH_NONE: b_sh_s = b_q;
      SH_LSL1: b_sh_s = {b_q[DATA_W-2:0], 1'b0};
      SH_LSR1: b_sh_s = {1'b0, b_q[DATA_W-1:1]};
      SH_ASR1: b_sh_s = {b_q[DATA_W-1], b_q[DATA_W-1:1]};
      default: b_sh_s = b_q;
    endcase
  end

  assign opa_s = asel_q ? {DATA_W{1'b0}} : a_q;
  assign opb_s = bsel_q ? sximm5_q : b_sh_s;

  // Overflow only when operand signs make it possible and the result sign flips.
  always_comb begin
    res_s = {DATA_W{1'b0}};
    v_s   = 1'b0;
    case (op_q)
      OP_ADD: begin
        res_s = opa_s + opb_s;
        v_s   = (opa_s[DATA_W-1] == opb_s[DATA_W-1]) && (res_s[DATA_W-1] != opa_s[DATA_W-1]);
      end
      OP_SUB: begin
        res_s = opa_s - opb_s;
        v_s   = (opa_s[DATA_W-1] != opb_s[DATA_W-1]) && (res_s[DATA_W-1] != opa_s[DATA_W-1]);
      end
      OP_AND:  res_s = opa_s & opb_s;
      OP_MVN:  res_s = ~opb_s;
      default: res_s = {DATA_W{1'b0}};
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      cmd_q    <= CMD_ALU;
      op_q     <= OP_ADD;
      shift_q  <= SH_NONE;
      rd_q     <= {REG_AW{1'b0}};
      rn_q     <= {REG_AW{1'b0}};
      rm_q     <= {REG_AW{1'b0}};
      asel_q   <= 1'b0;
      bsel_q   <= 1'b0;
      sximm5_q <= {DATA_W{1'b0}};
      wbval_q  <= {DATA_W{1'b0}};
      a_q      <= {DATA_W{1'b0}};
      b_q      <= {DATA_W{1'b0}};
      c_q      <= {DATA_W{1'b0}};
      n_q      <= 1'b0;
      v_q      <= 1'b0;
      z_q      <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != ST_IDLE);
      done_q  <= done_d;
      if (accept_s) begin
        cmd_q    <= cmd_e'(cmd);
        op_q     <= alu_op_e'(alu_op);
        shift_q  <= shift_e'(shift);
        rd_q     <= rd;
        rn_q     <= rn;
        rm_q     <= rm;
        asel_q   <= asel;
        bsel_q   <= bsel;
        sximm5_q <= sximm5;
        // MOVI/LDM writeback value is resolved now so later input changes cannot affect it.
        if (cmd_e'(cmd) == CMD_MOVI) wbval_q <= asel ? DATA_W'(pc) : sximm8;
        else                         wbval_q <= mdata;
      end
      if (state_q == ST_RDA) a_q <= rdata_a_s;
      if (state_q == ST_RDB) b_q <= rdata_b_s;
      if (state_q == ST_EXEC) begin
        c_q <= res_s;
        n_q <= res_s[DATA_W-1];
        v_q <= v_s;
        z_q <= (res_s == {DATA_W{1'b0}});
      end
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign c_out  = c_q;
  assign n_flag = n_q;
  assign v_flag = v_q;
  assign z_flag = z_q;

endmodule

// File: tb/tb_exec_datapath.sv
// Directed, table-driven bench for exec_datapath plus multi-cycle corner sequences.
module tb_exec_datapath;

  localparam logic [1:0] C_ALU = 2'd0, C_MOVI = 2'd1, C_LDM = 2'd2, C_CMP = 2'd3;
  localparam logic [1:0] O_ADD = 2'd0, O_SUB = 2'd1, O_AND = 2'd2, O_MVN = 2'd3;
  localparam logic [1:0] S_NONE = 2'd0, S_LSL = 2'd1, S_LSR = 2'd2, S_ASR = 2'd3;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  cmd = 2'd0, alu_op = 2'd0, shift = 2'd0;
  logic [2:0]  rd = 3'd0, rn = 3'd0, rm = 3'd0;
  logic        asel = 1'b0, bsel = 1'b0;
  logic [15:0] sximm5 = 16'd0, sximm8 = 16'd0, mdata = 16'd0;
  logic [7:0]  pc = 8'd0;
  logic        busy, done, n_flag, v_flag, z_flag;
  logic [15:0] c_out;

  int n_checks = 0;
  int n_fail   = 0;

  exec_datapath dut (
    .clk(clk), .reset_n(reset_n), .start(start), .cmd(cmd), .alu_op(alu_op),
    .shift(shift), .rd(rd), .rn(rn), .rm(rm), .asel(asel), .bsel(bsel),
    .sximm5(sximm5), .sximm8(sximm8), .mdata(mdata), .pc(pc),
    .busy(busy), .done(done), .c_out(c_out),
    .n_flag(n_flag), .v_flag(v_flag), .z_flag(z_flag)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [1:0]  cmd, op, sh;
    logic [2:0]  rd, rn, rm;
    logic        asel, bsel;
    logic [15:0] imm5, imm8, mdat;
    logic [7:0]  pcv;
    int          lat;
    logic [15:0] exp_c;
    logic [2:0]  exp_nvz;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string nm, logic [1:0] c, logic [1:0] op, logic [1:0] sh,
                              logic [2:0] d, logic [2:0] n, logic [2:0] m, logic as, logic bs,
                              logic [15:0] i5, logic [15:0] i8, logic [15:0] md, logic [7:0] p,
                              int lat, logic [15:0] ec, logic [2:0] nvz);
    vec_t v;
    v.name = nm; v.cmd = c; v.op = op; v.sh = sh; v.rd = d; v.rn = n; v.rm = m;
    v.asel = as; v.bsel = bs; v.imm5 = i5; v.imm8 = i8; v.mdat = md; v.pcv = p;
    v.lat = lat; v.exp_c = ec; v.exp_nvz = nvz;
    return v;
  endfunction

  function automatic vec_t movi(string nm, logic [2:0] d, logic [15:0] val, logic [15:0] ec, logic [2:0] nvz);
    return mk(nm, C_MOVI, O_ADD, S_NONE, d, 3'd0, 3'd0, 1'b0, 1'b0, 16'h0, val, 16'h0, 8'h0, 1, ec, nvz);
  endfunction

  function automatic vec_t alu(string nm, logic [1:0] op, logic [1:0] sh, logic [2:0] d, logic [2:0] n,
                               logic [2:0] m, logic as, logic bs, logic [15:0] i5, logic [15:0] ec, logic [2:0] nvz);
    return mk(nm, C_ALU, op, sh, d, n, m, as, bs, i5, 16'h0, 16'h0, 8'h0, 4, ec, nvz);
  endfunction

  // Readback: CMP with A forced to zero and ADD returns R[r] in c_out without writing.
  function automatic vec_t rdbk(string nm, logic [2:0] r, logic [15:0] ec, logic [2:0] nvz);
    return mk(nm, C_CMP, O_ADD, S_NONE, 3'd0, 3'd0, r, 1'b1, 1'b0, 16'h0, 16'h0, 16'h0, 8'h0, 3, ec, nvz);
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(vec_t v);
    cmd = v.cmd; alu_op = v.op; shift = v.sh; rd = v.rd; rn = v.rn; rm = v.rm;
    asel = v.asel; bsel = v.bsel; sximm5 = v.imm5; sximm8 = v.imm8; mdata = v.mdat; pc = v.pcv;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic run(vec_t v);
    int l;
    drive(v);
    chk({v.name, " busy"}, {31'd0, busy}, 32'd1);
    wait_done(l);
    chk({v.name, " lat"}, l, v.lat);
    chk({v.name, " c_out"}, {16'd0, c_out}, {16'd0, v.exp_c});
    chk({v.name, " nvz"}, {29'd0, n_flag, v_flag, z_flag}, {29'd0, v.exp_nvz});
  endtask

  initial begin
    int l;
    vecs.push_back(movi("movi_r0", 3'd0, 16'h0005, 16'h0000, 3'b000));
    vecs.push_back(movi("movi_r1", 3'd1, 16'h0003, 16'h0000, 3'b000));
    vecs.push_back(alu("add_r2", O_ADD, S_NONE, 3'd2, 3'd0, 3'd1, 1'b0, 1'b0, 16'h0, 16'h0008, 3'b000));
    vecs.push_back(mk("cmp_sub", C_CMP, O_SUB, S_NONE, 3'd2, 3'd1, 3'd0, 1'b0, 1'b0,
                      16'h0, 16'h0, 16'h0, 8'h0, 3, 16'hFFFE, 3'b100));
    vecs.push_back(rdbk("rb_r2", 3'd2, 16'h0008, 3'b000));
    vecs.push_back(rdbk("rb_r0", 3'd0, 16'h0005, 3'b000));
    vecs.push_back(rdbk("rb_r1", 3'd1, 16'h0003, 3'b000));
    vecs.push_back(movi("movi_r3", 3'd3, 16'h7FFF, 16'h0003, 3'b000));
    vecs.push_back(movi("movi_r4", 3'd4, 16'h0001, 16'h0003, 3'b000));
    vecs.push_back(alu("add_ovf", O_ADD, S_NONE, 3'd5, 3'd3, 3'd4, 1'b0, 1'b0, 16'h0, 16'h8000, 3'b110));
    vecs.push_back(movi("movi_r6", 3'd6, 16'hFFFF, 16'h8000, 3'b110));
    vecs.push_back(alu("mvn_zero", O_MVN, S_NONE, 3'd7, 3'd3, 3'd6, 1'b0, 1'b0, 16'h0, 16'h0000, 3'b001));
    vecs.push_back(alu("add_imm5", O_ADD, S_NONE, 3'd2, 3'd0, 3'd0, 1'b0, 1'b1, 16'hFFFE, 16'h0003, 3'b000));
    vecs.push_back(mk("ldm_r3", C_LDM, O_ADD, S_NONE, 3'd3, 3'd0, 3'd0, 1'b0, 1'b0,
                      16'h0, 16'h0, 16'h8004, 8'h0, 1, 16'h0003, 3'b000));
    vecs.push_back(alu("asr1", O_ADD, S_ASR, 3'd4, 3'd0, 3'd3, 1'b1, 1'b0, 16'h0, 16'hC002, 3'b100));
    vecs.push_back(mk("movi_pc", C_MOVI, O_ADD, S_NONE, 3'd5, 3'd0, 3'd0, 1'b1, 1'b0,
                      16'h0, 16'h1111, 16'h0, 8'hA5, 1, 16'hC002, 3'b100));
    vecs.push_back(rdbk("rb_r5", 3'd5, 16'h00A5, 3'b000));
    vecs.push_back(alu("sub_ovf", O_SUB, S_NONE, 3'd6, 3'd3, 3'd0, 1'b0, 1'b0, 16'h0, 16'h7FFF, 3'b010));
    vecs.push_back(alu("and_rd_eq_rn", O_AND, S_NONE, 3'd3, 3'd3, 3'd4, 1'b0, 1'b0, 16'h0, 16'h8000, 3'b100));
    vecs.push_back(rdbk("rb_r3", 3'd3, 16'h8000, 3'b100));
    vecs.push_back(mk("lsl1", C_CMP, O_ADD, S_LSL, 3'd0, 3'd0, 3'd0, 1'b1, 1'b0,
                      16'h0, 16'h0, 16'h0, 8'h0, 3, 16'h000A, 3'b000));
    vecs.push_back(mk("lsr1", C_CMP, O_ADD, S_LSR, 3'd0, 3'd0, 3'd3, 1'b1, 1'b0,
                      16'h0, 16'h0, 16'h0, 8'h0, 3, 16'h4000, 3'b000));
    vecs.push_back(rdbk("rb_r4", 3'd4, 16'hC002, 3'b100));
    vecs.push_back(rdbk("rb_r6", 3'd6, 16'h7FFF, 3'b000));

    repeat (3) @(posedge clk);
    #1;
    chk("rst c_out", {16'd0, c_out}, 32'd0);
    chk("rst nvz", {29'd0, n_flag, v_flag, z_flag}, 32'd0);
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst done", {31'd0, done}, 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Each vector starts in the done cycle of the previous one: back-to-back issue.
    foreach (vecs[i]) run(vecs[i]);

    // start held while busy must be ignored (would write 0x1234 into R7).
    drive(alu("busy_add", O_ADD, S_NONE, 3'd1, 3'd0, 3'd0, 1'b0, 1'b0, 16'h0, 16'h000A, 3'b000));
    cmd = C_MOVI; rd = 3'd7; sximm8 = 16'h1234; asel = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    chk("busy_mid busy", {31'd0, busy}, 32'd1);
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(l);
    chk("busy_add lat_rest", l, 2);
    chk("busy_add c_out", {16'd0, c_out}, 32'h000A);
    run(rdbk("rb_r7_untouched", 3'd7, 16'h0000, 3'b001));
    run(rdbk("rb_r1_new", 3'd1, 16'h000A, 3'b000));
    run(rdbk("rb_r4_pre_rst", 3'd4, 16'hC002, 3'b100));

    // Reset during EXEC: outputs clear at once, no writeback of R6.
    drive(alu("rst_add", O_ADD, S_NONE, 3'd6, 3'd0, 3'd0, 1'b0, 1'b0, 16'h0, 16'h0, 3'b000));
    @(posedge clk); #1;
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    chk("midrst c_out", {16'd0, c_out}, 32'd0);
    chk("midrst nvz", {29'd0, n_flag, v_flag, z_flag}, 32'd0);
    chk("midrst busy", {31'd0, busy}, 32'd0);
    chk("midrst done", {31'd0, done}, 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("postrst busy", {31'd0, busy}, 32'd0);
    chk("postrst done", {31'd0, done}, 32'd0);
    run(rdbk("rb_r0_cleared", 3'd0, 16'h0000, 3'b001));
    run(rdbk("rb_r6_cleared", 3'd6, 16'h0000, 3'b001));
    run(movi("movi_after_rst", 3'd2, 16'h0042, 16'h0000, 3'b001));
    run(rdbk("rb_r2_after_rst", 3'd2, 16'h0042, 3'b000));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
